// File: rtl/stream_pkg.sv
// stream_pkg: shared definitions for the FIFO read-side stream engine.
//   DATA_WIDTH : default data word width
//   beat_t     : one data word at the default width
//   last_beat  : true when a zero-based beat index is the final beat of a packet
package stream_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] beat_t;

  function automatic logic last_beat(input int unsigned cnt, input int unsigned len);
    return cnt == len - 1;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry in-order queue. entry0 is the head.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   push      : write push_data at this edge (caller guarantees occ<2 or a pop)
//   push_data : word to write
//   pop       : retire the head at this edge (caller guarantees occ!=0)
//   head_data : current head word
//   occ       : number of valid entries (0..2)
module skid_buf2
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) entry0 <= push_data;
          else             entry1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Head retires while a new word arrives: with one entry the new
          // word becomes the head directly; with two it queues behind entry1.
          if (occ == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = entry0;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a show-ahead FIFO and re-presents them
// as a valid/ready stream framed into PKT_LEN-beat packets.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   enable     : allows new pops; buffered words drain regardless
//   fifo_empty : FIFO empty flag
//   data_out   : FIFO head word (valid while fifo_empty=0)
//   r_ready    : pop strobe to the FIFO
//   m_valid    : output beat valid
//   m_data     : output beat data
//   m_last     : final beat of the current packet
//   m_ready    : downstream accept
//   pkt_count  : completed packets, wraps modulo 2^CNT_W
//   busy       : buffer holds at least one word
module fifo_stream_reader
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] data_out,
  output logic             r_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy
);

  localparam int unsigned BW = $clog2(PKT_LEN) + 1;

  logic [1:0]    occ;
  logic          hs;
  logic          at_last;
  logic [BW-1:0] beat_cnt;

  // Pop decision depends only on registered occupancy and the input flags,
  // so m_ready has no combinational path to r_ready.
  assign r_ready = reset & enable & ~fifo_empty & (occ < 2'd2);

  assign m_valid = (occ != 2'd0);
  assign busy    = m_valid;
  assign hs      = m_valid & m_ready;
  assign at_last = last_beat(32'(beat_cnt), PKT_LEN);
  assign m_last  = m_valid & at_last;

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (r_ready),
    .push_data(data_out),
    .pop      (hs),
    .head_data(m_data),
    .occ      (occ)
  );

  // Framing survives enable gaps: only handshakes advance beat_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else if (hs) begin
      if (at_last) begin
        beat_cnt  <= '0;
        pkt_count <= pkt_count + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int unsigned W   = 32;
  localparam int unsigned PKT = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty_m;
  logic          ovr;
  logic          ovr_empty;
  logic          fifo_empty;
  logic [W-1:0]  data_out;
  logic          r_ready;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_ready;
  logic [CW-1:0] pkt_count;
  logic          busy;

  assign fifo_empty = ovr ? ovr_empty : fifo_empty_m;

  always #10 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH  (W),
    .PKT_LEN(PKT),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .data_out  (data_out),
    .r_ready   (r_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  int unsigned tests  = 0;
  int unsigned errors = 0;

  logic [W-1:0] fq[$];     // words sitting in the FIFO
  logic [W-1:0] exp_q[$];  // words popped into the reader, not yet accepted
  int unsigned  beats = 0; // accepted beats since the last reset
  bit           mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: pops on an edge where r_ready is high; flags update after the edge.
  always @(posedge clk) begin
    if (r_ready) begin
      if (fq.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL pop_on_empty: got r_ready=1 expected no pop at %0t", $time);
      end else begin
        exp_q.push_back(fq.pop_front());
      end
    end
    fifo_empty_m <= (fq.size() == 0);
    data_out     <= (fq.size() != 0) ? fq[0] : W'($urandom);
  end

  // Reference model checked every cycle, from the stated rules.
  always @(negedge clk) begin
    if (mon_on) begin
      logic exp_v;
      logic exp_rr;
      exp_v  = (exp_q.size() != 0);
      exp_rr = reset && enable && !fifo_empty && (exp_q.size() < 2);
      check("mon_r_ready", 32'(r_ready), 32'(exp_rr));
      check("mon_m_valid", 32'(m_valid), 32'(exp_v));
      check("mon_busy", 32'(busy), 32'(exp_v));
      check("mon_m_last", 32'(m_last), 32'(exp_v && ((beats % PKT) == PKT - 1)));
      check("mon_pkt_count", 32'(pkt_count), (beats / PKT) % (1 << CW));
      if (exp_v) begin
        check("mon_m_data", m_data, exp_q[0]);
        if (m_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] d);
    fq.push_back(d);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    exp_q.delete();
    beats = 0;
    tick();
    reset = 1'b1;
  endtask

  task automatic collect(input logic [W-1:0] d, input logic l, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        got = 1'b1;
        break;
      end
    end
    check({nm, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({nm, "_data"}, m_data, d);
      check({nm, "_last"}, 32'(m_last), 32'(l));
    end
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic empty;
    logic exp_rr;
    logic exp_mv;
  } row_t;

  row_t rows[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pulses;
    bit          found;
    bit          drained;

    rows[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rows[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rows[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    rows[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset        = 1'b0;
    enable       = 1'b0;
    m_ready      = 1'b0;
    ovr          = 1'b0;
    ovr_empty    = 1'b1;
    fifo_empty_m = 1'b1;
    data_out     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_r_ready", 32'(r_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    reset  = 1'b1;
    mon_on = 1'b1;

    // Idle with an empty FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_r_ready", 32'(r_ready), 32'd0);
      check("idle_m_valid", 32'(m_valid), 32'd0);
      check("idle_pkt_count", 32'(pkt_count), 32'd0);
    end

    // Pop-rule table at occ=0, applied between clock edges
    tick();
    mon_on = 1'b0;
    ovr    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      reset     = rows[i].rst;
      enable    = rows[i].en;
      ovr_empty = rows[i].empty;
      #1;
      check("tbl_r_ready", 32'(r_ready), 32'(rows[i].exp_rr));
      check("tbl_m_valid", 32'(m_valid), 32'(rows[i].exp_mv));
    end
    reset  = 1'b1;
    enable = 1'b0;
    ovr    = 1'b0;
    mon_on = 1'b1;

    // Latency of a single word
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    push(32'hA5);
    @(negedge clk);
    check("lat_pre_r_ready", 32'(r_ready), 32'd0);
    @(negedge clk);
    check("lat_r_ready", 32'(r_ready), 32'd1);
    check("lat_m_valid0", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_m_valid1", 32'(m_valid), 32'd1);
    check("lat_m_data", m_data, 32'hA5);
    check("lat_r_ready_off", 32'(r_ready), 32'd0);
    @(negedge clk);
    check("lat_drained", 32'(m_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd0);

    // Streaming 0..7 at full rate
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(i));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("stream_start", 32'(found), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_data", m_data, 32'(i));
      check("stream_last", 32'(m_last), 32'((i % 4) == 3));
    end
    @(negedge clk);
    check("stream_pkt_count", 32'(pkt_count), 32'd2);
    check("stream_done", 32'(m_valid), 32'd0);

    // Backpressure
    do_reset();
    m_ready = 1'b0;
    enable  = 1'b1;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (r_ready) pulses++;
    end
    check("bp_pulses", pulses, 32'd2);
    check("bp_m_data", m_data, 32'd1);
    check("bp_fifo_empty", 32'(fifo_empty), 32'd0);
    check("bp_r_ready", 32'(r_ready), 32'd0);
    tick();
    m_ready = 1'b1;
    collect(32'd1, 1'b0, "bp_b0");
    collect(32'd2, 1'b0, "bp_b1");
    collect(32'd3, 1'b0, "bp_b2");

    // Enable gap mid-packet
    do_reset();
    m_ready = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 4; i++) push(32'd20 + 32'(i));
    repeat (4) @(negedge clk);
    tick();
    enable  = 1'b0;
    m_ready = 1'b1;
    collect(32'd20, 1'b0, "gap_b0");
    collect(32'd21, 1'b0, "gap_b1");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("gap_no_pop", 32'(r_ready), 32'd0);
      check("gap_idle", 32'(m_valid), 32'd0);
    end
    check("gap_fifo_level", fq.size(), 32'd2);
    tick();
    enable = 1'b1;
    collect(32'd22, 1'b0, "gap_b2");
    collect(32'd23, 1'b1, "gap_b3");
    @(negedge clk);
    check("gap_pkt_count", 32'(pkt_count), 32'd1);

    // Reset with two words buffered
    do_reset();
    m_ready = 1'b0;
    enable  = 1'b1;
    push(32'd30);
    push(32'd31);
    push(32'd32);
    repeat (4) @(negedge clk);
    check("mid_full", 32'(m_valid), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_m_valid", 32'(m_valid), 32'd0);
    check("mid_r_ready", 32'(r_ready), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    beats = 0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_pkt_count", 32'(pkt_count), 32'd0);
    push(32'd33);
    push(32'd34);
    push(32'd35);
    tick();
    m_ready = 1'b1;
    collect(32'd32, 1'b0, "mid_b0");
    collect(32'd33, 1'b0, "mid_b1");
    collect(32'd34, 1'b0, "mid_b2");
    collect(32'd35, 1'b1, "mid_b3");

    // Random traffic against the reference model (pkt_count wraps at 16)
    do_reset();
    for (int c = 0; c < 6000 && beats < 500; c++) begin
      tick();
      if (fq.size() < 4 && $urandom_range(0, 99) < 60) push(W'($urandom));
      m_ready = ($urandom_range(0, 99) < 70);
      enable  = ($urandom_range(0, 99) < 85);
    end
    check("rnd_beats", 32'(beats >= 500), 32'd1);
    tick();
    enable  = 1'b1;
    m_ready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && exp_q.size() == 0 && !m_valid) begin
        drained = 1'b1;
        break;
      end
    end
    check("rnd_drained", 32'(drained), 32'd1);
    @(negedge clk);
    mon_on = 1'b0;
    check("rnd_pkt_count", 32'(pkt_count), (beats / PKT) % (1 << CW));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
